// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART receive controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Receive controller states; IDLE must stay at encoding 0 (reset value).
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_ctrl_state_t;

  // Default oversampling ratio (ticks per bit period).
  localparam int c_oversample_default = 16;

  // Vote ticks for the default ratio; other ratios keep the same offsets
  // around the bit centre (OVERSAMPLE/2).
  localparam int c_vote_tick_first = c_oversample_default / 2 - 1;
  localparam int c_vote_tick_mid   = c_oversample_default / 2;
  localparam int c_vote_tick_last  = c_oversample_default / 2 + 1;

  // Two-out-of-three majority used for the bit vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Oversample tick generator; one-cycle pulse every
//                max(baud_div,1) clocks, restartable to realign on a start edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] c_one = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] r_count;
  logic [DIV_WIDTH-1:0] w_last;
  logic                 w_wrap;

  // A divisor of 0 behaves like 1, so the terminal count is 0 in both cases.
  assign w_last = (baud_div == '0) ? '0 : (baud_div - c_one);
  // Using >= lets a divisor that shrinks mid-count wrap on the next cycle.
  assign w_wrap = (r_count >= w_last);
  assign tick   = w_wrap & ~restart;

  // Free-running divider counter, cleared on restart so the first tick lands
  // one full divisor period after the start edge.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_count <= '0;
    end else if (w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : Oversampling UART receiver with majority vote, even parity
//                (per byte or per word), framing check and a valid/ready
//                output register with sticky overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = c_oversample_default,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_per_byte,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int c_tw = $clog2(OVERSAMPLE) + 1;
  localparam int c_bw = $clog2(DATA_WIDTH + 1);

  localparam logic [c_tw-1:0] c_tick_one  = c_tw'(1);
  localparam logic [c_tw-1:0] c_tick_last = c_tw'(OVERSAMPLE - 1);
  localparam logic [c_tw-1:0] c_vote_a    =
    c_tw'(OVERSAMPLE / 2 + (c_vote_tick_first - c_oversample_default / 2));
  localparam logic [c_tw-1:0] c_vote_b    =
    c_tw'(OVERSAMPLE / 2 + (c_vote_tick_mid - c_oversample_default / 2));
  localparam logic [c_tw-1:0] c_vote_c    =
    c_tw'(OVERSAMPLE / 2 + (c_vote_tick_last - c_oversample_default / 2));
  localparam logic [c_bw-1:0] c_bit_one   = c_bw'(1);
  localparam logic [c_bw-1:0] c_bit_full  = c_bw'(DATA_WIDTH);

  rx_ctrl_state_t r_state;
  rx_ctrl_state_t w_state_nxt;

  logic                  r_sync1, r_sync2, r_sync_prev;
  logic                  w_fall;
  logic                  w_tick;
  logic                  w_restart;
  logic [c_tw-1:0]       r_tick_cnt;
  logic [c_tw-1:0]       w_tick_num;
  logic                  w_at_vote;
  logic                  w_bit_end;
  logic                  r_samp_a, r_samp_b;
  logic                  w_vote;
  logic [c_bw-1:0]       r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  r_perr;
  logic                  w_shift_en;
  logic                  w_par_chk;
  logic                  w_complete;
  logic                  w_to_parity;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid, r_parity_err, r_frame_err, r_overrun;

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .restart  (w_restart),
    .baud_div (baud_div),
    .tick     (w_tick)
  );

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= rx_in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  assign w_fall      = r_sync_prev & ~r_sync2;
  assign w_tick_num  = r_tick_cnt + c_tick_one;
  assign w_at_vote   = w_tick & (w_tick_num == c_vote_c);
  assign w_bit_end   = w_tick & (r_tick_cnt == c_tick_last);
  assign w_vote      = majority3(r_samp_a, r_samp_b, r_sync2);
  assign w_to_parity = (parity_per_byte && (r_bit_cnt[2:0] == 3'd0)) ||
                       (r_bit_cnt == c_bit_full);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-tick action strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_chk   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && w_fall) begin
          w_state_nxt = ST_START;
          w_restart   = 1'b1;
        end
      end
      ST_START: begin
        if (w_at_vote && w_vote) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bit_end) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_shift_en = w_at_vote;
        if (w_bit_end) begin
          w_state_nxt = w_to_parity ? ST_PARITY : ST_DATA;
        end
      end
      ST_PARITY: begin
        w_par_chk = w_at_vote;
        if (w_bit_end) begin
          w_state_nxt = (r_bit_cnt == c_bit_full) ? ST_STOP : ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_at_vote) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit timing, vote samples, shift register and parity accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_samp_a   <= 1'b1;
      r_samp_b   <= 1'b1;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
    end else if (w_restart) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      if (w_tick && (r_state != ST_IDLE)) begin
        r_tick_cnt <= (r_tick_cnt == c_tick_last) ? '0 : w_tick_num;
      end
      if (w_tick && (w_tick_num == c_vote_a)) begin
        r_samp_a <= r_sync2;
      end
      if (w_tick && (w_tick_num == c_vote_b)) begin
        r_samp_b <= r_sync2;
      end
      if (w_shift_en) begin
        r_shift   <= {w_vote, r_shift[DATA_WIDTH-1:1]};
        r_bit_cnt <= r_bit_cnt + c_bit_one;
        r_par     <= r_par ^ w_vote;
      end
      if (w_par_chk) begin
        if (w_vote != r_par) begin
          r_perr <= 1'b1;
        end
        if (parity_per_byte) begin
          r_par <= 1'b0;
        end
      end
    end
  end

  // Output holding register: load on completion when free (or being drained
  // this cycle), otherwise drop the frame and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_complete && (!r_valid || ready)) begin
      r_data       <= r_shift;
      r_parity_err <= r_perr;
      r_frame_err  <= ~w_vote;
      r_valid      <= 1'b1;
    end else begin
      if (w_complete) begin
        r_overrun <= 1'b1;
      end
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame; SHALL be a multiple of 8 when parity_per_byte is used.
REQ-002 Parameter OVERSAMPLE, default 16, ticks per bit period; SHALL be at least 8.
REQ-003 Parameter DIV_WIDTH, default 16, width of the baud divisor.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_in  input  1  asynchronous serial line, idle high.
REQ-007 enable  input  1  permits detection of new start bits.
REQ-008 baud_div  input  DIV_WIDTH  clk cycles per oversample tick; a value of 0 SHALL be treated as 1.
REQ-009 parity_per_byte  input  1  1 = one parity bit after every 8 data bits; 0 = one parity bit after the last data bit.
REQ-010 data  output  DATA_WIDTH  received payload, LSB received first.
REQ-011 valid / ready  output / input  1 each  data handshake.
REQ-012 parity_err, frame_err  output  1 each  error flags for the frame held on data.
REQ-013 overrun  output  1  sticky flag: a completed frame was dropped.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 rx_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-016 Tick generator: pulse one cycle every max(baud_div,1) cycles; it SHALL be restarted on the start-edge detection cycle.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE -> START when enable=1 and a synchronized falling edge occurs; otherwise stay in IDLE.
REQ-019 Each bit value SHALL be the majority of the samples at ticks 7, 8 and 9 (scaled as OVERSAMPLE/2-1 .. OVERSAMPLE/2+1) of that bit's tick count.
REQ-020 START: if the voted bit is 1 (glitch), return to IDLE with no output; otherwise go to DATA at the end of the bit period.
REQ-021 DATA: shift the voted bit in LSB-first and increment bit_count. After bit_count%8==7 with parity_per_byte=1, or after bit DATA_WIDTH-1, go to PARITY.
REQ-022 PARITY: even parity. Error is set when the voted bit differs from the XOR of the covered bits (the current byte, or the whole word). Per-byte errors SHALL accumulate (OR). After the last parity bit go to STOP; otherwise return to DATA.
REQ-023 STOP: frame_err = (voted bit == 0). Frame completion is at the stop-bit tick 9, then return to IDLE; stop-bit remainder is not waited.
REQ-024 Completion with valid=0, or with valid&ready in the same cycle: data, parity_err and frame_err SHALL be loaded; valid SHALL be 1 on the following cycle.
REQ-025 Completion with valid=1 and ready=0: the new frame SHALL be dropped, held data left unchanged, and overrun set.
REQ-026 valid SHALL stay high and outputs stable until a cycle with valid&ready; valid SHALL clear the next cycle unless REQ-024 reloads it.
REQ-027 enable deassertion SHALL not abort a frame in progress.
REQ-028 baud_div changes mid-frame take effect on the next tick period and are not otherwise checked.

Reset
REQ-029 rst SHALL force: state IDLE, all counters 0, data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-030 Reset mid-frame SHALL discard the partial frame with no valid pulse.
REQ-031 overrun SHALL be cleared only by rst.

Structure
REQ-032 Package uart_pkg SHALL hold the rx_ctrl_state_t enum and the OVERSAMPLE default and vote-tick constants.
REQ-033 The tick generator SHALL be a sub-module, uart_baud_gen (clk, rst, restart, baud_div, tick).

Verification (DATA_WIDTH=8, baud_div=4, 64 clk per bit unless stated)
REQ-034 Frame 0xA5, parity 0, stop 1, ready=1 -> data=0xA5, valid for exactly 1 cycle, no error flags.
REQ-035 rx_in low for 8 cycles, then high -> START, then IDLE; valid never asserts.
REQ-036 Frame 0x01 with parity 0 -> parity_err=1. Frame 0x01 with stop 0 -> frame_err=1.
REQ-037 Frames 0x11 then 0x22 with ready=0 -> data stays 0x11, overrun=1. Then ready=1 -> valid drops and overrun stays 1.
REQ-038 DATA_WIDTH=16, parity_per_byte=1, frame 0x1234 with parity bits 1,0 (first byte, 0x34, is sent first) -> data=0x1234, parity_err=0. Flipping the first parity bit -> parity_err=1.
REQ-039 rst pulse at data bit 4 -> no valid, busy=0 next cycle, and the next clean frame 0x5A is received correctly.
